// File: rtl/sprite_index_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_index_fetch
//  Description : Per-pixel sprite front end. Hit-tests the beam against the
//                sprite box, forms the sprite ROM address (with animation
//                frame and horizontal flip), and returns a 3-clock pipelined
//                palette index plus an opaque flag. Index 0 is transparent.
//                Optional build macro SPRITE_ONESHOT_EN: the animation stops
//                on its last frame and raises anim_done instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_index_fetch #(
    parameter int SPR_W       = 64,
    parameter int SPR_H       = 96,
    parameter int FRAMES      = 4,
    parameter int FRAME_TICKS = 6,
    parameter int ADDR_W      = 15
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              vs,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        SpriteX,
    input  logic [9:0]        SpriteY,
    input  logic              flip,
    input  logic              anim_en,
    input  logic              anim_restart,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        pix_index,
    output logic              pix_opaque,
    output logic [1:0]        anim_frame,
    output logic              anim_done
);

    // Pixels per animation frame in ROM.
    localparam int C_FRAME_SIZE = SPR_W * SPR_H;
    // Tick counter only needs to reach FRAME_TICKS-1.
    localparam int C_TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [C_TICK_W-1:0] C_TICK_LAST  = C_TICK_W'(FRAME_TICKS - 1);
    localparam logic [1:0]          C_FRAME_LAST = 2'(FRAMES - 1);

`ifdef SPRITE_ONESHOT_EN
    localparam bit C_ONESHOT = 1'b1;
`else
    localparam bit C_ONESHOT = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Frame-edge detection and per-frame latches
    // ------------------------------------------------------------------
    logic                r_vs_prev;
    logic                w_frame_edge;
    logic [9:0]          r_sx;
    logic [9:0]          r_sy;
    logic                r_flip;

    // Animation state
    logic [C_TICK_W-1:0] r_tick;
    logic [1:0]          r_frame;
    logic                w_advance;
    logic                w_at_last;

    // Hit test / address math
    logic [10:0]         w_x_end;
    logic [10:0]         w_y_end;
    logic                w_hit;
    logic [9:0]          w_lx;
    logic [9:0]          w_ly;
    logic [9:0]          w_lx_f;
    logic [ADDR_W-1:0]   w_addr;

    // Pipeline registers
    logic [ADDR_W-1:0]   r_rom_addr;
    logic                r_hit1;
    logic                r_hit2;
    logic [3:0]          r_pix_index;
    logic                r_pix_opaque;

    // vsync is active low: a frame starts where the registered copy is
    // still high and the live input has dropped.
    assign w_frame_edge = r_vs_prev & ~vs;

    // Register vs once for edge detection; idles high like the sync line.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_vs_prev <= 1'b1;
        end else begin
            r_vs_prev <= vs;
        end
    end

    // Capture position and flip only at the frame boundary so the sprite
    // never tears while a frame is being scanned.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sx   <= '0;
            r_sy   <= '0;
            r_flip <= 1'b0;
        end else if (w_frame_edge) begin
            r_sx   <= SpriteX;
            r_sy   <= SpriteY;
            r_flip <= flip;
        end
    end

    // ------------------------------------------------------------------
    // Animation: tick counts frame edges; frame steps every FRAME_TICKS.
    // ------------------------------------------------------------------
    assign w_advance = w_frame_edge & anim_en & (r_tick == C_TICK_LAST);
    assign w_at_last = (r_frame == C_FRAME_LAST);

    // Tick/frame update; restart is honoured on any clock and beats an edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_tick  <= '0;
            r_frame <= '0;
        end else if (anim_restart) begin
            r_tick  <= '0;
            r_frame <= '0;
        end else if (w_frame_edge) begin
            if (!anim_en || (r_tick == C_TICK_LAST)) begin
                r_tick <= '0;
            end else begin
                r_tick <= r_tick + C_TICK_W'(1);
            end
            if (w_advance) begin
                if (!w_at_last) begin
                    r_frame <= r_frame + 2'd1;
                end else if (!C_ONESHOT) begin
                    r_frame <= '0;
                end
            end
        end
    end

    assign anim_frame = r_frame;

`ifdef SPRITE_ONESHOT_EN
    logic r_done;

    // Sticky completion flag: set by the advance that would have wrapped.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_done <= 1'b0;
        end else if (anim_restart) begin
            r_done <= 1'b0;
        end else if (w_advance && w_at_last) begin
            r_done <= 1'b1;
        end
    end

    assign anim_done = r_done;
`else
    assign anim_done = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage 1 combinational: hit test and ROM address. Comparisons are done
    // in 11 bits so a sprite hanging off the right/bottom edge cannot wrap.
    // ------------------------------------------------------------------
    always_comb begin
        w_x_end = {1'b0, r_sx} + 11'(SPR_W);
        w_y_end = {1'b0, r_sy} + 11'(SPR_H);
        w_hit   = ({1'b0, DrawX} >= {1'b0, r_sx}) && ({1'b0, DrawX} < w_x_end) &&
                  ({1'b0, DrawY} >= {1'b0, r_sy}) && ({1'b0, DrawY} < w_y_end);
        w_lx    = DrawX - r_sx;
        w_ly    = DrawY - r_sy;
        w_lx_f  = r_flip ? (10'(SPR_W - 1) - w_lx) : w_lx;
        w_addr  = '0;
        if (w_hit) begin
            w_addr = ADDR_W'(r_frame) * ADDR_W'(C_FRAME_SIZE) +
                     ADDR_W'(w_ly) * ADDR_W'(SPR_W) +
                     ADDR_W'(w_lx_f);
        end
    end

    // Stage 1/2 registers: address to ROM, hit delayed alongside ROM latency.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rom_addr <= '0;
            r_hit1     <= 1'b0;
            r_hit2     <= 1'b0;
        end else begin
            r_rom_addr <= w_addr;
            r_hit1     <= w_hit;
            r_hit2     <= r_hit1;
        end
    end

    assign rom_addr = r_rom_addr;

    // Stage 3: mask the ROM data outside the sprite and flag opaque pixels.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pix_index  <= '0;
            r_pix_opaque <= 1'b0;
        end else begin
            r_pix_index  <= r_hit2 ? rom_data : 4'd0;
            r_pix_opaque <= r_hit2 && (rom_data != 4'd0);
        end
    end

    assign pix_index  = r_pix_index;
    assign pix_opaque = r_pix_opaque;

endmodule
`default_nettype wire

// File: tb/tb_sprite_index_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_index_fetch
//  Description : Scoreboard bench for sprite_index_fetch with a behavioural
//                sprite model and a synchronous ROM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_index_fetch;

    localparam int SPR_W       = 64;
    localparam int SPR_H       = 96;
    localparam int FRAMES      = 4;
    localparam int FRAME_TICKS = 6;
    localparam int ADDR_W      = 15;
    localparam int IDLE        = 1023;

    typedef struct packed {
        logic [3:0] idx;
        logic       op;
    } pix_t;

    logic              clk = 1'b0;
    logic              Reset_n;
    logic              vs;
    logic [9:0]        DrawX, DrawY, SpriteX, SpriteY;
    logic              flip, anim_en, anim_restart;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data;
    logic [3:0]        pix_index;
    logic              pix_opaque;
    logic [1:0]        anim_frame;
    logic              anim_done;

    int checks   = 0;
    int failures = 0;

    // Expected-response queues filled by stimulus, drained by the monitor.
    int   addr_q[$];
    pix_t pix_q[$];

    // Reference model state.
    int m_sx, m_sy, m_frame, m_tick;
    bit m_flip, m_done, prev_vs;

    always #5 clk = ~clk;

    sprite_index_fetch #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES),
        .FRAME_TICKS(FRAME_TICKS), .ADDR_W(ADDR_W)
    ) dut (
        .Clk(clk), .Reset_n(Reset_n), .vs(vs),
        .DrawX(DrawX), .DrawY(DrawY), .SpriteX(SpriteX), .SpriteY(SpriteY),
        .flip(flip), .anim_en(anim_en), .anim_restart(anim_restart),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_index(pix_index), .pix_opaque(pix_opaque),
        .anim_frame(anim_frame), .anim_done(anim_done)
    );

    // Arbitrary ROM contents; zero appears often enough to exercise transparency.
    function automatic logic [3:0] rom_f(input int a);
        logic [31:0] t;
        t = a ^ (a >> 4) ^ (a >> 9);
        return t[3:0];
    endfunction

    // Synchronous ROM, one clock read latency.
    always @(posedge clk) rom_data <= rom_f(int'(rom_addr));

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > IDLE) ? IDLE : v);
    endfunction

    // Expected result for one beam position under the current model state.
    function automatic void push_expect(input int x, input int y);
        int   a;
        int   lx;
        pix_t p;
        a = 0;
        p = '0;
        if (x >= m_sx && x < m_sx + SPR_W && y >= m_sy && y < m_sy + SPR_H) begin
            lx    = m_flip ? (SPR_W - 1 - (x - m_sx)) : (x - m_sx);
            a     = m_frame * SPR_W * SPR_H + (y - m_sy) * SPR_W + lx;
            p.idx = rom_f(a);
            p.op  = (p.idx != 4'd0);
        end
        addr_q.push_back(a);
        pix_q.push_back(p);
    endfunction

    function automatic void model_reset();
        m_sx = 0; m_sy = 0; m_flip = 0;
        m_frame = 0; m_tick = 0; m_done = 0;
        prev_vs = 1;
    endfunction

    // One frame-edge worth of animation, from the behavioural rules.
    function automatic void anim_step(input bit en);
        if (!en) begin
            m_tick = 0;
        end else begin
            m_tick++;
            if (m_tick == FRAME_TICKS) begin
                m_tick = 0;
                if (m_frame < FRAMES - 1) m_frame++;
`ifdef SPRITE_ONESHOT_EN
                else m_done = 1;
`else
                else m_frame = 0;
`endif
            end
        end
    endfunction

    task automatic drive_pix(input int x, input int y);
        @(negedge clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        push_expect(x, y);
    endtask

    task automatic idle_cycle(input bit v, input bit rs);
        bit edge_seen;
        @(negedge clk);
        vs           = v;
        anim_restart = rs;
        DrawX        = 10'(IDLE);
        DrawY        = 10'(IDLE);
        edge_seen    = prev_vs && !v;
        if (edge_seen) begin
            m_sx = int'(SpriteX); m_sy = int'(SpriteY); m_flip = flip;
        end
        if (rs) begin
            m_tick = 0; m_frame = 0; m_done = 0;
        end else if (edge_seen) begin
            anim_step(anim_en);
        end
        prev_vs = v;
        push_expect(IDLE, IDLE);
    endtask

    task automatic vsync(input bit rs);
        idle_cycle(1, 0);
        idle_cycle(0, rs);
        repeat (3) idle_cycle(0, 0);
        repeat (2) idle_cycle(1, 0);
        chk("anim_frame", 32'(anim_frame), 32'(m_frame));
        chk("anim_done", 32'(anim_done), 32'(m_done));
    endtask

    task automatic rand_pixels(input int n);
        for (int i = 0; i < n; i++)
            drive_pix(clamp(m_sx - 4 + int'($urandom_range(0, 72))),
                      clamp(m_sy - 4 + int'($urandom_range(0, 104))));
    endtask

    task automatic release_reset();
        @(negedge clk);
        Reset_n = 1'b1; vs = 1'b1; anim_restart = 1'b0;
        DrawX = 10'(IDLE); DrawY = 10'(IDLE);
        push_expect(IDLE, IDLE);
    endtask

    // Monitor: every clock compares the DUT against the queued expectations.
    initial begin : monitor
        int   ea;
        pix_t ep;
        forever begin
            @(posedge clk);
            #1;
            if (Reset_n === 1'b1) begin
                ea = 0;
                ep = '0;
                if (addr_q.size() > 0) ea = addr_q.pop_front();
                if (pix_q.size() >= 3) ep = pix_q.pop_front();
                chk("rom_addr", 32'(rom_addr), 32'(ea));
                chk("pix_index", 32'(pix_index), 32'(ep.idx));
                chk("pix_opaque", 32'(pix_opaque), 32'(ep.op));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        Reset_n = 1'b0; vs = 1'b1; anim_restart = 1'b0; anim_en = 1'b0;
        DrawX = 10'(IDLE); DrawY = 10'(IDLE);
        SpriteX = '0; SpriteY = '0; flip = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_rom_addr", 32'(rom_addr), 0);
        chk("reset_pix_index", 32'(pix_index), 0);
        chk("reset_pix_opaque", 32'(pix_opaque), 0);
        chk("reset_anim_frame", 32'(anim_frame), 0);
        chk("reset_anim_done", 32'(anim_done), 0);
        release_reset();

        // Basic hit/miss and corners at SX=100, SY=200.
        SpriteX = 10'd100; SpriteY = 10'd200; flip = 1'b0;
        vsync(0);
        drive_pix(100, 200); drive_pix(163, 295); drive_pix(99, 200);
        drive_pix(164, 200); drive_pix(100, 296); drive_pix(130, 250);
        rand_pixels(150);
        // Pending changes mid-frame must not take effect yet.
        SpriteX = 10'd300; flip = 1'b1;
        drive_pix(100, 200); drive_pix(163, 295);
        rand_pixels(50);

        // Flipped sprite.
        SpriteX = 10'd100; SpriteY = 10'd200; flip = 1'b1;
        vsync(0);
        drive_pix(100, 200); drive_pix(163, 200);
        SpriteX = 10'd50; flip = 1'b0;
        drive_pix(100, 200);
        rand_pixels(100);

        // Animation through a full cycle of frames.
        flip = 1'b0;
        anim_en = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            vsync(0);
            drive_pix(100, 200); drive_pix(163, 295);
            rand_pixels(8);
            if (i == 6) chk("frame_after_6", 32'(anim_frame), 1);
        end
`ifdef SPRITE_ONESHOT_EN
        chk("frame_after_24", 32'(anim_frame), 3);
        chk("done_after_24", 32'(anim_done), 1);
`else
        chk("frame_after_24", 32'(anim_frame), 0);
        chk("done_after_24", 32'(anim_done), 0);
`endif
        for (int i = 0; i < 12; i++) vsync(0);
        // Restart coincident with a frame edge wins.
        vsync(1);
        chk("frame_after_restart", 32'(anim_frame), 0);
        chk("done_after_restart", 32'(anim_done), 0);
        for (int i = 0; i < 6; i++) vsync(0);
        anim_en = 1'b0;
        for (int i = 0; i < 10; i++) vsync(0);
        chk("frame_held", 32'(anim_frame), 1);
        drive_pix(100, 200);
        anim_en = 1'b1;
        for (int i = 0; i < 6; i++) vsync(0);

        // Randomised frames: position, flip, enable and restarts.
        for (int f = 0; f < 24; f++) begin
            SpriteX = 10'($urandom_range(0, 639));
            SpriteY = 10'($urandom_range(0, 479));
            flip    = 1'($urandom_range(0, 1));
            anim_en = ($urandom_range(0, 3) != 0);
            vsync($urandom_range(0, 9) == 0);
            SpriteX = 10'($urandom_range(0, 639));
            flip    = 1'($urandom_range(0, 1));
            rand_pixels(60);
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle(1, 1);
                idle_cycle(1, 0);
                rand_pixels(20);
            end
        end

        // Asynchronous reset in the middle of a line of hits.
        SpriteX = 10'd20; SpriteY = 10'd30; flip = 1'b0; anim_en = 1'b1;
        vsync(1);
        for (int i = 0; i < 6; i++) vsync(0);
        for (int x = 20; x < 40; x++) drive_pix(x, 40);
        @(posedge clk);
        #3;
        Reset_n = 1'b0;
        addr_q.delete();
        pix_q.delete();
        model_reset();
        #1;
        chk("async_rom_addr", 32'(rom_addr), 0);
        chk("async_pix_index", 32'(pix_index), 0);
        chk("async_pix_opaque", 32'(pix_opaque), 0);
        chk("async_anim_frame", 32'(anim_frame), 0);
        chk("async_anim_done", 32'(anim_done), 0);
        repeat (3) @(negedge clk);
        release_reset();
        for (int x = 0; x < 80; x++) drive_pix(x, 5);
        rand_pixels(40);

        repeat (6) idle_cycle(1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
